// File: rtl/shift_seq_unit.sv
// Iterative shifter/rotator (SLL/SRL/SRA/ROR/ROL) that moves one bit position per clock.
// Latency: DONE arrives SHAMT+1 cycles after the accept edge; issue interval is SHAMT+2.
// Backpressure: START is taken only while READY=1; requests in SHIFT/FIN are dropped, not queued.
module shift_seq_unit #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_FIRST_ILLEGAL = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             op_illegal;
  logic [WIDTH-1:0] wreg;
  logic [WIDTH-1:0] step;
  logic [2:0]       op_q;
  logic [SHW-1:0]   cnt;
  logic             err_q;

  assign op_illegal = (op >= OP_FIRST_ILLEGAL);

  // State register; reset aborts any operation in flight without a DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. Zero shifts and illegal ops skip SHIFT entirely.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept = 1'b1;
          if ((shamt == '0) || op_illegal) begin
            state_nxt = S_FIN;
          end else begin
            state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (cnt == SHW'(1)) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // One-bit step of the latched operation; SRA replicates the current MSB (the original sign).
  always_comb begin
    step = wreg;
    case (op_q)
      OP_SLL:  step = {wreg[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, wreg[WIDTH-1:1]};
      OP_SRA:  step = {wreg[WIDTH-1], wreg[WIDTH-1:1]};
      OP_ROR:  step = {wreg[0], wreg[WIDTH-1:1]};
      OP_ROL:  step = {wreg[WIDTH-2:0], wreg[WIDTH-1]};
      default: step = wreg;
    endcase
  end

  // Working register, op and count: loaded on accept, stepped once per SHIFT cycle, held otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wreg  <= '0;
      op_q  <= OP_SLL;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      wreg  <= data;
      op_q  <= op;
      cnt   <= shamt;
      err_q <= op_illegal;
    end else if (state == S_SHIFT) begin
      wreg  <= step;
      cnt   <= cnt - SHW'(1);
    end
  end

  assign result = wreg;
  assign err    = err_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
module tb_shift_seq_unit;

  localparam logic [2:0] SLL = 3'b000;
  localparam logic [2:0] SRL = 3'b001;
  localparam logic [2:0] SRA = 3'b010;
  localparam logic [2:0] ROR = 3'b011;
  localparam logic [2:0] ROL = 3'b100;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] op;
  logic [7:0] data;
  logic [2:0] shamt;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       err;

  int checks;
  int errors;

  shift_seq_unit #(.WIDTH(8), .SHW(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .data    (data),
    .shamt   (shamt),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request in cycle c0 (inputs change at negedge, outputs sampled at negedge),
  // scrambles the inputs after the accept edge, and records what happened per cycle.
  // pulse_at > 0 raises START for that single cycle while the operation is in flight.
  task automatic run_op(input logic [2:0] o, input logic [7:0] d, input logic [2:0] s,
                        input int pulse_at,
                        output int done_cyc, output int ndone, output int nbusy,
                        output int busy_first, output int busy_last, output int ready_cyc,
                        output logic [7:0] res, output logic e);
    @(negedge clk);
    start = 1'b1; op = o; data = d; shamt = s;
    done_cyc = -1; ndone = 0; nbusy = 0; busy_first = -1; busy_last = -1; ready_cyc = -1;
    res = 8'hxx; e = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        op = 3'b111; data = ~d; shamt = 3'd0;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = c; res = result; e = err;
        end
      end
      if (busy) begin
        nbusy++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (ready && ready_cyc < 0) ready_cyc = c;
      start = (c == pulse_at);
      if (ready_cyc >= 0) begin
        start = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b0; op = SLL; data = 8'h00; shamt = 3'd0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, busy, done, result, err} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b busy=%b done=%b res=%h err=%b, expected 1 0 0 00 0",
               ready, busy, done, result, err);
    end
    reset_n = 1'b1;
  endtask

  // Directed shift cases: operation, operand, amount, hand-computed result.
  task automatic test_shifts();
    logic [2:0] t_op  [8] = '{SLL,   SRA,   SRL,   ROR,   ROL,   ROL,   ROR,   SRA};
    logic [7:0] t_dat [8] = '{8'h81, 8'h90, 8'hF0, 8'h81, 8'h81, 8'hB4, 8'h96, 8'h70};
    logic [2:0] t_sh  [8] = '{3'd1,  3'd3,  3'd7,  3'd1,  3'd1,  3'd4,  3'd3,  3'd2};
    logic [7:0] t_exp [8] = '{8'h02, 8'hF2, 8'h01, 8'hC0, 8'h03, 8'h4B, 8'hD2, 8'h1C};
    int dc, nd, nb, bf, bl, rc;
    logic [7:0] r;
    logic e;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_dat[i], t_sh[i], 0, dc, nd, nb, bf, bl, rc, r, e);
      checks++;
      if (r !== t_exp[i] || e !== 1'b0) begin
        errors++;
        $display("FAIL shift_result[%0d]: op=%0d data=%h sh=%0d got %h err=%b, expected %h err=0",
                 i, t_op[i], t_dat[i], t_sh[i], r, e, t_exp[i]);
      end
      checks++;
      if (dc !== int'(t_sh[i]) + 1 || nd !== 1 || rc !== int'(t_sh[i]) + 2) begin
        errors++;
        $display("FAIL shift_timing[%0d]: done at c%0d (%0d pulses) ready at c%0d, expected c%0d x1, ready c%0d",
                 i, dc, nd, rc, int'(t_sh[i]) + 1, int'(t_sh[i]) + 2);
      end
      checks++;
      if (nb !== int'(t_sh[i]) || bf !== 1 || bl !== int'(t_sh[i])) begin
        errors++;
        $display("FAIL shift_busy[%0d]: busy %0d cycles c%0d..c%0d, expected c1..c%0d",
                 i, nb, bf, bl, t_sh[i]);
      end
    end
  endtask

  task automatic test_zero_and_illegal();
    int dc, nd, nb, bf, bl, rc;
    logic [7:0] r;
    logic e;
    run_op(SLL, 8'h5A, 3'd0, 0, dc, nd, nb, bf, bl, rc, r, e);
    checks++;
    if (r !== 8'h5A || e !== 1'b0 || dc !== 1 || nb !== 0 || rc !== 2) begin
      errors++;
      $display("FAIL zero_shamt: res=%h err=%b done c%0d busy=%0d ready c%0d, expected 5a 0 c1 0 c2",
               r, e, dc, nb, rc);
    end
    run_op(3'b111, 8'h3C, 3'd5, 0, dc, nd, nb, bf, bl, rc, r, e);
    checks++;
    if (r !== 8'h3C || e !== 1'b1 || dc !== 1 || nb !== 0) begin
      errors++;
      $display("FAIL illegal_111: res=%h err=%b done c%0d busy=%0d, expected 3c 1 c1 0", r, e, dc, nb);
    end
    run_op(3'b101, 8'hA5, 3'd2, 0, dc, nd, nb, bf, bl, rc, r, e);
    checks++;
    if (r !== 8'hA5 || e !== 1'b1 || dc !== 1) begin
      errors++;
      $display("FAIL illegal_101: res=%h err=%b done c%0d, expected a5 1 c1", r, e, dc);
    end
    // ERR is held after DONE, then cleared by the next legal accept.
    checks++;
    if (err !== 1'b1 || result !== 8'hA5) begin
      errors++;
      $display("FAIL err_hold: err=%b res=%h in idle, expected 1 a5", err, result);
    end
    run_op(ROL, 8'h01, 3'd1, 0, dc, nd, nb, bf, bl, rc, r, e);
    checks++;
    if (r !== 8'h02 || e !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: res=%h err=%b, expected 02 0", r, e);
    end
  endtask

  task automatic test_start_ignored();
    int dc, nd, nb, bf, bl, rc;
    logic [7:0] r;
    logic e;
    run_op(SRL, 8'hF0, 3'd7, 2, dc, nd, nb, bf, bl, rc, r, e);
    checks++;
    if (nd !== 1 || dc !== 8 || r !== 8'h01 || rc !== 9) begin
      errors++;
      $display("FAIL start_ignored: %0d dones first c%0d res=%h ready c%0d, expected 1 c8 01 c9",
               nd, dc, r, rc);
    end
    // One more cycle must stay idle: the mid-flight pulse was not queued.
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_not_queued: rdy=%b busy=%b done=%b, expected 1 0 0", ready, busy, done);
    end
  endtask

  task automatic test_mid_reset();
    int nd;
    int dc, nb, bf, bl, rc;
    logic [7:0] r;
    logic e;
    nd = 0;
    @(negedge clk);
    start = 1'b1; op = SLL; data = 8'hFF; shamt = 3'd6;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) nd++;
      if (c == 3) reset_n = 1'b0;
      if (c == 4) reset_n = 1'b1;
    end
    checks++;
    if ({ready, busy, done, result, err} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_state: rdy=%b busy=%b done=%b res=%h err=%b, expected 1 0 0 00 0",
               ready, busy, done, result, err);
    end
    for (int c = 5; c <= 14; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: saw %0d dones, expected 0", nd);
    end
    run_op(SLL, 8'h01, 3'd2, 0, dc, nd, nb, bf, bl, rc, r, e);
    checks++;
    if (r !== 8'h04 || dc !== 3) begin
      errors++;
      $display("FAIL mid_reset_recover: res=%h done c%0d, expected 04 c3", r, dc);
    end
  endtask

  // Second request issued in the very cycle READY returns: interval SHAMT+2.
  task automatic test_back_to_back();
    int d1, d2, rc;
    logic [7:0] r1, r2;
    d1 = -1; d2 = -1; rc = -1; r1 = 8'hxx; r2 = 8'hxx;
    @(negedge clk);
    start = 1'b1; op = SLL; data = 8'h01; shamt = 3'd1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin d1 = c; r1 = result; end
        else if (d2 < 0) begin d2 = c; r2 = result; end
      end
      if (c >= 2 && ready && rc < 0) rc = c;
      if (c == 3) begin
        start = 1'b1; op = ROL; data = 8'h80; shamt = 3'd2;
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (d1 !== 2 || r1 !== 8'h02 || rc !== 3) begin
      errors++;
      $display("FAIL b2b_first: done c%0d res=%h ready c%0d, expected c2 02 c3", d1, r1, rc);
    end
    checks++;
    if (d2 !== 6 || r2 !== 8'h02) begin
      errors++;
      $display("FAIL b2b_second: done c%0d res=%h, expected c6 02", d2, r2);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    start = 1'b0;
    op = SLL;
    data = 8'h00;
    shamt = 3'd0;
    test_reset();
    test_shifts();
    test_zero_and_illegal();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
